// File: rtl/dbu_pkg.sv
// Shared constants for the debug/stepping controller: address stride,
// probe-view encoding and the address wrap-mask helper.
package dbu_pkg;

    // Byte stride between consecutive probed words.
    localparam int ADDR_STEP = 4;

    // sel value that selects the memory/register probe view.
    localparam logic [2:0] VIEW_PROBE = 3'b000;

    // Wrap mask for a probe space of 'words' words: keeps the in-range byte
    // address bits and forces the two byte-offset bits to zero, so a masked
    // add/subtract wraps modulo words*ADDR_STEP and stays word aligned.
    function automatic logic [31:0] wrap_mask(input int words);
        logic [31:0] span;
        span = 32'(words * ADDR_STEP);
        return (span - 32'd1) & ~32'(ADDR_STEP - 1);
    endfunction

endpackage

// File: rtl/debug_unit_btn_pulse.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter that accepts
// a new level after DEB_CYCLES consecutive differing samples, and a one-cycle
// pulse on each accepted 0->1 transition.
module btn_pulse #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain; sync[1] is safe to use.
    // NOTE: rst sits in the sensitivity list so every flop clears immediately,
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a shift chain.
            sync <= {sync[0], btn};
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so short bounces are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
                pulse <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Debug/stepping controller around the pipelined CPU core: produces the run
// enable, status selectors and probe address from switches and buttons, and
// multiplexes CPU debug outputs onto the LED and 7-segment buses.
module debug_unit
    import dbu_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int MEM_WORDS  = 256,
    parameter int RF_WORDS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        succ,
    input  logic        step,
    input  logic [2:0]  sel,
    input  logic        m_rf,
    input  logic        inc,
    input  logic        dec,
    input  logic [31:0] status,
    input  logic [15:0] control_sign,
    input  logic [31:0] m_data,
    input  logic [31:0] r_data,
    output logic        run,
    output logic [2:0]  sel0,
    output logic [1:0]  sel1,
    output logic [31:0] m_rf_addr,
    output logic [15:0] led,
    output logic [31:0] disp
);

    localparam logic [31:0] MEM_MASK = wrap_mask(MEM_WORDS);
    localparam logic [31:0] RF_MASK  = wrap_mask(RF_WORDS);
    localparam logic [31:0] STEP     = 32'(ADDR_STEP);

    logic        step_p;
    logic        inc_p;
    logic        dec_p;
    logic        m_rf_q;
    logic        sel_change;
    logic        mrf_change;
    logic        probe_mode;
    logic        inc_only;
    logic        dec_only;
    logic [31:0] addr_mask;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_step (.clk(clk), .rst(rst), .btn(step), .pulse(step_p));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_inc  (.clk(clk), .rst(rst), .btn(inc),  .pulse(inc_p));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_dec  (.clk(clk), .rst(rst), .btn(dec),  .pulse(dec_p));

    // Decode view changes, active mode and net button direction for this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally), so no latch can be inferred.
        sel_change = (sel != sel0);
        mrf_change = (m_rf != m_rf_q);
        probe_mode = (sel0 == VIEW_PROBE);
        inc_only   = inc_p & ~dec_p;
        dec_only   = dec_p & ~inc_p;
        addr_mask  = m_rf_q ? MEM_MASK : RF_MASK;
    end

    // Run enable: free-run while succ is high, otherwise one cycle per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= succ | step_p;
    end

    // Registered view selectors; sel0 goes straight to the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel0   <= 3'b000;
            m_rf_q <= 1'b0;
        end else begin
            sel0   <= sel;
            m_rf_q <= m_rf;
        end
    end

    // Sub-select counter; a view change clears it and swallows any pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel1 <= 2'b00;
        end else if (sel_change) begin
            sel1 <= 2'b00;
        end else if (!probe_mode && inc_only) begin
            sel1 <= sel1 + 2'd1;
        end else if (!probe_mode && dec_only) begin
            sel1 <= sel1 - 2'd1;
        end
    end

    // Probe address: word steps wrapped to the active space. A memory/register
    // switch clears it; a view change just drops a coincident pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rf_addr <= '0;
        end else if (mrf_change) begin
            m_rf_addr <= '0;
        end else if (sel_change) begin
            m_rf_addr <= m_rf_addr;
        end else if (probe_mode && inc_only) begin
            m_rf_addr <= (m_rf_addr + STEP) & addr_mask;
        end else if (probe_mode && dec_only) begin
            m_rf_addr <= (m_rf_addr - STEP) & addr_mask;
        end
    end

    // Display and LED multiplexers driven from the registered selectors.
    always_comb begin
        if (probe_mode) begin
            disp = m_rf_q ? m_data : r_data;
            led  = {8'b0, m_rf_addr[9:2]};
        end else begin
            disp = status;
            led  = control_sign;
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit with a short debounce window.
module tb_debug_unit;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        succ;
    logic        step;
    logic [2:0]  sel;
    logic        m_rf;
    logic        inc;
    logic        dec;
    logic [31:0] status;
    logic [15:0] control_sign;
    logic [31:0] m_data;
    logic [31:0] r_data;
    logic        run;
    logic [2:0]  sel0;
    logic [1:0]  sel1;
    logic [31:0] m_rf_addr;
    logic [15:0] led;
    logic [31:0] disp;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {A_NONE, A_INC, A_DEC, A_BOTH} act_e;

    typedef struct {
        logic [2:0]  sel;
        logic        m_rf;
        act_e        act;
        logic [31:0] addr;
        logic [1:0]  sel1;
        logic [15:0] led;
        logic [31:0] disp;
    } vec_t;

    localparam logic [31:0] ST = 32'hDEAD_BEEF;
    localparam logic [15:0] CS = 16'h00A5;
    localparam logic [31:0] MD = 32'h1111_1111;
    localparam logic [31:0] RD = 32'h2222_2222;

    vec_t vecs [17];

    debug_unit #(.DEB_CYCLES(DEB), .MEM_WORDS(256), .RF_WORDS(32)) dut (
        .clk(clk), .rst(rst), .succ(succ), .step(step), .sel(sel), .m_rf(m_rf),
        .inc(inc), .dec(dec), .status(status), .control_sign(control_sign),
        .m_data(m_data), .r_data(r_data), .run(run), .sel0(sel0), .sel1(sel1),
        .m_rf_addr(m_rf_addr), .led(led), .disp(disp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press held long enough to be accepted, then a clean release.
    task automatic press(input act_e a);
        inc = (a == A_INC) || (a == A_BOTH);
        dec = (a == A_DEC) || (a == A_BOTH);
        tick(8);
        inc = 1'b0;
        dec = 1'b0;
        tick(8);
    endtask

    // Count run pulses over n cycles.
    task automatic count_run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (run === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int first;
        int ones;
        logic [2:0]  sel_m;
        logic        mrf_m;
        int          addr_m;
        int          sel1_m;
        int          span;
        logic [2:0]  new_sel;
        act_e        a;

        vecs[0]  = '{3'd0, 1'b1, A_NONE, 32'h000, 2'd0, 16'h0000, MD};
        vecs[1]  = '{3'd0, 1'b1, A_DEC,  32'h3FC, 2'd0, 16'h00FF, MD};
        vecs[2]  = '{3'd0, 1'b1, A_INC,  32'h000, 2'd0, 16'h0000, MD};
        vecs[3]  = '{3'd0, 1'b1, A_INC,  32'h004, 2'd0, 16'h0001, MD};
        vecs[4]  = '{3'd0, 1'b1, A_INC,  32'h008, 2'd0, 16'h0002, MD};
        vecs[5]  = '{3'd0, 1'b0, A_NONE, 32'h000, 2'd0, 16'h0000, RD};
        vecs[6]  = '{3'd0, 1'b0, A_DEC,  32'h07C, 2'd0, 16'h001F, RD};
        vecs[7]  = '{3'd0, 1'b0, A_BOTH, 32'h07C, 2'd0, 16'h001F, RD};
        vecs[8]  = '{3'd0, 1'b0, A_INC,  32'h000, 2'd0, 16'h0000, RD};
        vecs[9]  = '{3'd3, 1'b0, A_INC,  32'h000, 2'd1, CS, ST};
        vecs[10] = '{3'd3, 1'b0, A_INC,  32'h000, 2'd2, CS, ST};
        vecs[11] = '{3'd3, 1'b0, A_INC,  32'h000, 2'd3, CS, ST};
        vecs[12] = '{3'd3, 1'b0, A_INC,  32'h000, 2'd0, CS, ST};
        vecs[13] = '{3'd3, 1'b0, A_INC,  32'h000, 2'd1, CS, ST};
        vecs[14] = '{3'd3, 1'b0, A_DEC,  32'h000, 2'd0, CS, ST};
        vecs[15] = '{3'd4, 1'b0, A_NONE, 32'h000, 2'd0, CS, ST};
        vecs[16] = '{3'd4, 1'b0, A_INC,  32'h000, 2'd1, CS, ST};

        rst = 1'b1; succ = 1'b0; step = 1'b0; sel = 3'd0; m_rf = 1'b0;
        inc = 1'b0; dec = 1'b0;
        status = ST; control_sign = CS; m_data = MD; r_data = RD;

        // Reset state.
        tick(3);
        check("rst_run", run, 0);
        check("rst_sel0", sel0, 0);
        check("rst_sel1", sel1, 0);
        check("rst_addr", m_rf_addr, 0);
        check("rst_led", led, 0);
        check("rst_disp", disp, RD);
        rst = 1'b0;
        tick(2);

        // Single step: one run pulse exactly 7 edges after the press.
        step = 1'b1;
        pulses = 0;
        first = -1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (run === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        check("step_pulses", pulses, 1);
        check("step_latency", first, 7);
        step = 1'b0;
        count_run(10, pulses);
        check("step_release", pulses, 0);

        // Free-run ignores step; run drops the cycle after succ falls.
        succ = 1'b1;
        tick(1);
        step = 1'b1;
        ones = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (run === 1'b1) ones++;
        end
        check("succ_run_ones", ones, 10);
        succ = 1'b0;
        tick(1);
        check("succ_fall_run", run, 0);
        step = 1'b0;
        count_run(10, pulses);
        check("succ_after_pulses", pulses, 0);

        // Table: probe addressing, wrap, simultaneous buttons, sub-select.
        for (int i = 0; i < 17; i++) begin
            sel  = vecs[i].sel;
            m_rf = vecs[i].m_rf;
            tick(2);
            press(vecs[i].act);
            check($sformatf("vec%0d_sel0", i), sel0, vecs[i].sel);
            check($sformatf("vec%0d_addr", i), m_rf_addr, vecs[i].addr);
            check($sformatf("vec%0d_sel1", i), sel1, vecs[i].sel1);
            check($sformatf("vec%0d_led", i), led, vecs[i].led);
            check($sformatf("vec%0d_disp", i), disp, vecs[i].disp);
        end

        // Bouncing step: exactly one pulse once the level settles.
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            step = (b % 2 == 0);
            for (int c = 0; c < 2; c++) begin
                tick(1);
                if (run === 1'b1) pulses++;
            end
        end
        step = 1'b1;
        count_run(12, ones);
        pulses += ones;
        step = 1'b0;
        count_run(10, ones);
        pulses += ones;
        check("bounce_pulses", pulses, 1);

        // A memory/register switch coinciding with an inc pulse wins.
        sel = 3'd0;
        m_rf = 1'b1;
        tick(3);
        press(A_INC);
        check("pre_clear_addr", m_rf_addr, 32'h4);
        inc = 1'b1;
        tick(6);
        m_rf = 1'b0;
        tick(1);
        check("clear_wins_addr", m_rf_addr, 0);
        inc = 1'b0;
        tick(10);
        check("clear_wins_hold", m_rf_addr, 0);

        // Randomised operations against a spec-level model.
        sel_m = 3'd0; mrf_m = 1'b0; addr_m = 0; sel1_m = 0;
        for (int it = 0; it < 40; it++) begin
            status       = $urandom;
            control_sign = 16'($urandom);
            m_data       = $urandom;
            r_data       = $urandom;
            case ($urandom_range(0, 4))
                0: begin
                    new_sel = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
                    if (new_sel != sel_m) sel1_m = 0;
                    sel_m = new_sel;
                    sel = new_sel;
                    tick(2);
                end
                1: begin
                    mrf_m = ~mrf_m;
                    addr_m = 0;
                    m_rf = mrf_m;
                    tick(2);
                end
                default: begin
                    a = act_e'($urandom_range(1, 3));
                    press(a);
                    if (a != A_BOTH) begin
                        if (sel_m == 3'd0) begin
                            span = mrf_m ? 256 * 4 : 32 * 4;
                            addr_m = (addr_m + span + ((a == A_INC) ? 4 : -4)) % span;
                        end else begin
                            sel1_m = (sel1_m + 4 + ((a == A_INC) ? 1 : -1)) % 4;
                        end
                    end
                end
            endcase
            check($sformatf("rnd%0d_sel0", it), sel0, sel_m);
            check($sformatf("rnd%0d_sel1", it), sel1, sel1_m);
            check($sformatf("rnd%0d_addr", it), m_rf_addr, addr_m);
            check($sformatf("rnd%0d_led", it), led,
                  (sel_m == 3'd0) ? 32'(addr_m / 4) : 32'(control_sign));
            check($sformatf("rnd%0d_disp", it), disp,
                  (sel_m == 3'd0) ? (mrf_m ? m_data : r_data) : status);
        end

        // Reset mid-debounce clears everything at once.
        r_data = 32'h0;
        sel = 3'd0;
        m_rf = 1'b1;
        tick(3);
        for (int k = 0; k < 4; k++) press(A_INC);
        check("prerst_addr", m_rf_addr, 32'h10);
        step = 1'b1;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_run", run, 0);
        check("arst_sel0", sel0, 0);
        check("arst_sel1", sel1, 0);
        check("arst_addr", m_rf_addr, 0);
        check("arst_led", led, 0);
        check("arst_disp", disp, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        step = 1'b0;
        count_run(15, pulses);
        check("arst_short_hold", pulses, 0);
        step = 1'b1;
        count_run(12, pulses);
        check("arst_long_hold", pulses, 1);
        step = 1'b0;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
